// File: rtl/cnt5_ctrl.sv
// rtl/cnt5_ctrl.sv - run/halt/load sequencer for the 5-digit counter (optional CNT5_CTRL_AUTORELOAD_EN)
module cnt5_ctrl #(
  parameter int LOAD_HOLD_P = 2
) (
  input  logic        CLOCK_50,
  input  logic        nReset,
  input  logic        start_n,
  input  logic        load_n,
  input  logic [7:0]  preset,
  input  logic [19:0] target,
  input  logic [19:0] count,
  output logic        cnt_enable,
  output logic        cnt_nLoad,
  output logic [7:0]  cnt_load_val,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HALT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(LOAD_HOLD_P - 1);

  state_t     cur_state;
  state_t     nxt_state;
  logic       start_q;
  logic       load_q;
  logic [3:0] hold_cnt;
  logic       from_done;
  logic       start_press;
  logic       load_press;
  logic       load_entry;

  assign start_press = start_q & ~start_n;
  assign load_press  = load_q & ~load_n;
  assign load_entry  = (nxt_state == S_LOAD) && (cur_state != S_LOAD);

  // One-cycle-old copy of the buttons so a held button yields a single press
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      start_q <= 1'b1;
      load_q  <= 1'b1;
    end else begin
      start_q <= start_n;
      load_q  <= load_n;
    end
  end

  // State register
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) cur_state <= S_IDLE;
    else         cur_state <= nxt_state;
  end

  // Next-state logic; load always wins over start
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE: begin
        if (load_press)       nxt_state = S_LOAD;
        else if (start_press) nxt_state = S_RUN;
      end
      S_LOAD: begin
        if (hold_cnt == HOLD_LAST) nxt_state = from_done ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (load_press)            nxt_state = S_LOAD;
        else if (count == target)  nxt_state = S_DONE;
        else if (start_press)      nxt_state = S_HALT;
      end
      S_HALT: begin
        if (load_press)       nxt_state = S_LOAD;
        else if (start_press) nxt_state = S_RUN;
      end
      S_DONE: begin
`ifdef CNT5_CTRL_AUTORELOAD_EN
        nxt_state = S_LOAD;
`else
        if (load_press) nxt_state = S_LOAD;
`endif
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Preset capture, load-hold timing and where LOAD returns to
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      cnt_load_val <= 8'd0;
      hold_cnt     <= 4'd0;
      from_done    <= 1'b0;
    end else if (load_entry) begin
      cnt_load_val <= preset;
      hold_cnt     <= 4'd0;
`ifdef CNT5_CTRL_AUTORELOAD_EN
      from_done    <= (cur_state == S_DONE);
`else
      from_done    <= 1'b0;
`endif
    end else if (cur_state == S_LOAD) begin
      hold_cnt <= hold_cnt + 4'd1;
    end
  end

  assign cnt_enable = (cur_state == S_RUN);
  assign cnt_nLoad  = (cur_state != S_LOAD);
  assign done       = (cur_state == S_DONE);
  assign state      = cur_state;

endmodule
